// File: rtl/rx_filter_pkg.sv
// rx_filter_pkg: shared reason codes, header offsets, config map and FSM encoding for the RX frame filter.
package rx_filter_pkg;
  typedef enum logic [2:0] {IDLE, DST_MAC, SRC_MAC, ETYPE, IP_HDR, TAIL} state_t;
  localparam logic [2:0] RSN_OK = 3'd0;
  localparam logic [2:0] RSN_ERR = 3'd1;
  localparam logic [2:0] RSN_RUNT = 3'd2;
  localparam logic [2:0] RSN_MAC = 3'd3;
  localparam logic [2:0] RSN_ETYPE = 3'd4;
  localparam logic [2:0] RSN_IP = 3'd5;
  localparam logic [10:0] OFF_SRC = 11'd6;
  localparam logic [10:0] OFF_ETYPE = 11'd12;
  localparam logic [10:0] OFF_IP = 11'd14;
  localparam logic [10:0] OFF_DIP = 11'd30;
  localparam logic [10:0] OFF_DIP_END = 11'd33;
  localparam logic [10:0] OFF_IP_END = 11'd34;
  localparam logic [15:0] ETYPE_IPV4 = 16'h0800;
  localparam logic [3:0] CFG_MAC_HI = 4'd8;
  localparam logic [3:0] CFG_MAC_LO = 4'd9;
  localparam logic [3:0] CFG_CTRL = 4'd10;
  function automatic state_t state_of(input logic [10:0] idx);
    return idx < OFF_SRC ? DST_MAC : idx < OFF_ETYPE ? SRC_MAC :
           idx < OFF_IP ? ETYPE : idx < OFF_IP_END ? IP_HDR : TAIL;
  endfunction
endpackage

// File: rtl/rx_ip_match.sv
// rx_ip_match: IPv4 destination table with per-entry enable mask and a parallel compare.
module rx_ip_match
  import rx_filter_pkg::*;
#(
  parameter int NUM_IP = 5,
  parameter logic [31:0] IP_BASE = {8'd192, 8'd168, 8'd0, 8'd1}
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic [31:0] ip,
  output logic        match
);
  logic [31:0] tbl [NUM_IP];
  logic [NUM_IP-1:0] en;
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_IP; k++) tbl[k] <= IP_BASE + 32'(k);
      en <= '1;
    end else if (cfg_we) begin
      if (cfg_addr == CFG_CTRL) en <= cfg_wdata[NUM_IP-1:0];
      for (int k = 0; k < NUM_IP; k++) if (cfg_addr == 4'(k)) tbl[k] <= cfg_wdata;
    end
  end
  always_comb begin
    match = 1'b0;
    for (int k = 0; k < NUM_IP; k++) match = match | (en[k] && tbl[k] == ip);
  end
endmodule

// File: rtl/rx_frame_filter_ctrl.sv
// rx_frame_filter_ctrl: parses received frames byte by byte and issues one accept/drop verdict per frame.
module rx_frame_filter_ctrl
  import rx_filter_pkg::*;
#(
  parameter int NUM_IP = 5,
  parameter logic [47:0] MAC_DEFAULT = 48'h386b1c1df565,
  parameter logic [31:0] IP_BASE = {8'd192, 8'd168, 8'd0, 8'd1}
) (
  input  logic        rx_clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  input  logic        in_eof,
  input  logic        in_err,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic        verdict_valid,
  output logic        verdict_accept,
  output logic [2:0]  verdict_reason,
  output logic [15:0] accept_cnt,
  output logic [15:0] drop_cnt
);
  state_t state, state_nx;
  logic [10:0] idx, cur_idx, idx_inc;
  logic err, cur_err, active, abort, fire, mac_ok, ip_hit;
  logic [47:0] dmac, station_mac;
  logic [15:0] etype;
  logic [31:0] dip, dip_nx;
  logic promisc;
  logic [2:0] rsn;
  rx_ip_match #(.NUM_IP(NUM_IP), .IP_BASE(IP_BASE)) u_ip (
    .rx_clk(rx_clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .ip(dip_nx), .match(ip_hit)
  );
  always_comb begin
    cur_idx = in_sof ? 11'd0 : idx;
    idx_inc = (cur_idx == 11'h7FF) ? cur_idx : cur_idx + 11'd1;
    active = in_valid && (in_sof || state != IDLE);
    abort = in_valid && in_sof && state != IDLE;
    fire = abort || (active && in_eof);
    cur_err = (!in_sof && err) || in_err;
    // the last dst IP byte may arrive on the eof byte itself
    dip_nx = (cur_idx >= OFF_DIP && cur_idx <= OFF_DIP_END) ? {dip[23:0], in_data} : dip;
    mac_ok = promisc || dmac == station_mac || dmac == '1;
    rsn = (abort || in_sof) ? RSN_RUNT : cur_err ? RSN_ERR : cur_idx < OFF_DIP_END ? RSN_RUNT :
          !mac_ok ? RSN_MAC : etype != ETYPE_IPV4 ? RSN_ETYPE : !ip_hit ? RSN_IP : RSN_OK;
    state_nx = in_eof ? IDLE : state_of(idx_inc);
  end
  always_ff @(posedge rx_clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      err <= 1'b0;
      dmac <= '0;
      etype <= '0;
      dip <= '0;
      verdict_valid <= 1'b0;
      verdict_accept <= 1'b0;
      verdict_reason <= RSN_OK;
      accept_cnt <= '0;
      drop_cnt <= '0;
      station_mac <= MAC_DEFAULT;
      promisc <= 1'b0;
    end else begin
      verdict_valid <= fire;
      if (fire) begin
        verdict_accept <= rsn == RSN_OK;
        verdict_reason <= rsn;
        if (rsn == RSN_OK && accept_cnt != 16'hFFFF) accept_cnt <= accept_cnt + 16'd1;
        if (rsn != RSN_OK && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      end
      if (active) begin
        state <= state_nx;
        idx <= in_eof ? 11'd0 : idx_inc;
        err <= cur_err;
        dip <= dip_nx;
        if (cur_idx < OFF_SRC) dmac <= {dmac[39:0], in_data};
        if (cur_idx == OFF_ETYPE || cur_idx == OFF_ETYPE + 11'd1) etype <= {etype[7:0], in_data};
      end
      if (cfg_we && cfg_addr == CFG_MAC_HI) station_mac[47:32] <= cfg_wdata[15:0];
      if (cfg_we && cfg_addr == CFG_MAC_LO) station_mac[31:0] <= cfg_wdata;
      if (cfg_we && cfg_addr == CFG_CTRL) promisc <= cfg_wdata[8];
    end
  end
endmodule

// File: tb/tb_rx_frame_filter_ctrl.sv
// tb_rx_frame_filter_ctrl: directed frames with hand-computed verdicts and a small counter model.
module tb_rx_frame_filter_ctrl;
  logic rx_clk = 1'b0, reset = 1'b1;
  logic in_valid = 1'b0, in_sof = 1'b0, in_eof = 1'b0, in_err = 1'b0;
  logic [7:0] in_data = '0;
  logic cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic verdict_valid, verdict_accept;
  logic [2:0] verdict_reason;
  logic [15:0] accept_cnt, drop_cnt;
  int total = 0, bad = 0;
  logic [15:0] exp_acc = '0, exp_drop = '0;
  logic [47:0] f_mac;
  logic [15:0] f_et;
  logic [31:0] f_ip;
  rx_frame_filter_ctrl dut (
    .rx_clk(rx_clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_sof(in_sof), .in_eof(in_eof), .in_err(in_err), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .verdict_valid(verdict_valid),
    .verdict_accept(verdict_accept), .verdict_reason(verdict_reason),
    .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
  );
  always #5 rx_clk = ~rx_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] fbyte(input int i);
    if (i < 6) return f_mac[8*(5-i) +: 8];
    if (i == 12) return f_et[15:8];
    if (i == 13) return f_et[7:0];
    if (i >= 30 && i <= 33) return f_ip[8*(33-i) +: 8];
    return 8'(i);
  endfunction
  task automatic put(input logic v, input logic s, input logic e, input logic r, input logic [7:0] d);
    @(negedge rx_clk);
    in_valid = v; in_sof = s; in_eof = e; in_err = r; in_data = d;
  endtask
  task automatic cfg(input logic [3:0] a, input logic [31:0] d);
    @(negedge rx_clk);
    in_valid = 1'b0; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    @(negedge rx_clk);
    cfg_we = 1'b0;
  endtask
  task automatic count(input logic [2:0] r);
    if (r == 3'd0) begin
      if (exp_acc != 16'hFFFF) exp_acc++;
    end else if (exp_drop != 16'hFFFF) exp_drop++;
  endtask
  task automatic send(input string tag, input int len, input int err_at, input bit no_eof,
                      input bit exp_abort, input logic [2:0] exp_rsn);
    for (int i = 0; i < len; i++) begin
      put(1'b1, i == 0, (i == len - 1) && !no_eof, i == err_at, fbyte(i));
      if (i == 1 && exp_abort) begin
        chk({tag, "_abort_v"}, verdict_valid, 1);
        chk({tag, "_abort_rsn"}, verdict_reason, 2);
        count(3'd2);
        chk({tag, "_abort_drop"}, drop_cnt, exp_drop);
      end
    end
    if (!no_eof) begin
      put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk({tag, "_v"}, verdict_valid, 1);
      chk({tag, "_rsn"}, verdict_reason, exp_rsn);
      chk({tag, "_acc"}, verdict_accept, exp_rsn == 3'd0);
      count(exp_rsn);
      chk({tag, "_acnt"}, accept_cnt, exp_acc);
      chk({tag, "_dcnt"}, drop_cnt, exp_drop);
      put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      chk({tag, "_pulse"}, verdict_valid, 0);
    end
  endtask
  initial begin
    f_mac = 48'h386b1c1df565; f_et = 16'h0800; f_ip = 32'hC0A80003;
    repeat (3) put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_v", verdict_valid, 0);
    chk("rst_acc", verdict_accept, 0);
    chk("rst_rsn", verdict_reason, 0);
    chk("rst_acnt", accept_cnt, 0);
    chk("rst_dcnt", drop_cnt, 0);
    send("ok64", 64, -1, 0, 0, 3'd0);
    f_ip = 32'hC0A80009;
    send("ipmiss", 64, -1, 0, 0, 3'd5);
    cfg(4'd0, 32'hC0A80009);
    send("ipnew", 64, -1, 0, 0, 3'd0);
    f_mac = '1; f_et = 16'h0806;
    send("arp", 64, -1, 0, 0, 3'd4);
    f_mac = 48'h020000000001; f_et = 16'h0800; f_ip = 32'hC0A80003;
    send("macmiss", 64, -1, 0, 0, 3'd3);
    cfg(4'd10, 32'h11F);
    send("promisc_ok", 64, -1, 0, 0, 3'd0);
    f_ip = 32'h0A000001;
    send("promisc_ipmiss", 64, -1, 0, 0, 3'd5);
    cfg(4'd10, 32'h01E);
    f_mac = 48'h386b1c1df565; f_ip = 32'hC0A80009;
    send("masked", 64, -1, 0, 0, 3'd5);
    cfg(4'd10, 32'h01F);
    f_ip = 32'hC0A80005;
    send("err20", 64, 20, 0, 0, 3'd1);
    send("runt20", 20, -1, 0, 0, 3'd2);
    send("eof33", 34, -1, 0, 0, 3'd0);
    send("eof32", 33, -1, 0, 0, 3'd2);
    send("sofeof", 1, -1, 0, 0, 3'd2);
    send("trunc40", 40, -1, 1, 0, 3'd0);
    send("after_abort", 64, -1, 0, 1, 3'd0);
    for (int i = 0; i < 4; i++) put(1'b1, 1'b0, i == 3, 1'b0, 8'h55);
    put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stray_v0", verdict_valid, 0);
    put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("stray_v1", verdict_valid, 0);
    cfg(4'd8, 32'hFFFF0A0B);
    cfg(4'd9, 32'h0C0D0E0F);
    send("oldmac", 64, -1, 0, 0, 3'd3);
    f_mac = 48'h0A0B0C0D0E0F;
    send("newmac", 64, -1, 0, 0, 3'd0);
    cfg(4'd7, 32'hC0A80005);
    send("unmapped", 64, -1, 0, 0, 3'd0);
    @(negedge rx_clk);
    force dut.accept_cnt = 16'hFFFE;
    @(negedge rx_clk);
    release dut.accept_cnt;
    exp_acc = 16'hFFFE;
    send("sat1", 64, -1, 0, 0, 3'd0);
    send("sat2", 64, -1, 0, 0, 3'd0);
    f_mac = 48'h386b1c1df565; f_ip = 32'hC0A80003;
    for (int i = 0; i <= 25; i++) begin
      put(1'b1, i == 0, 1'b0, 1'b0, fbyte(i));
      if (i == 25) reset = 1'b1;
    end
    put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    reset = 1'b0;
    chk("mid_rst_v", verdict_valid, 0);
    chk("mid_rst_acc", verdict_accept, 0);
    chk("mid_rst_rsn", verdict_reason, 0);
    chk("mid_rst_acnt", accept_cnt, 0);
    chk("mid_rst_dcnt", drop_cnt, 0);
    exp_acc = '0; exp_drop = '0;
    put(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("mid_rst_v2", verdict_valid, 0);
    send("post_rst", 64, -1, 0, 0, 3'd0);
    f_ip = 32'hC0A80009;
    send("post_rst_tbl", 64, -1, 0, 0, 3'd5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rx_frame_filter_ctrl.md
RX_FRAME_FILTER_CTRL -- requirements
Module: rx_frame_filter_ctrl

Interface
REQ-001 Parameter NUM_IP, default 5: number of IPv4 destination filter entries (1..8).
REQ-002 Parameter MAC_DEFAULT, default 48'h386b1c1df565: station MAC loaded at reset.
REQ-003 Parameter IP_BASE, default {192,168,0,1}: entry k resets to IP_BASE+k.
REQ-004 rx_clk  in  1  receive clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset, sampled on rx_clk.
REQ-006 in_valid  in  1  byte strobe from the GMII receiver (post-SFD bytes, dst MAC first).
REQ-007 in_data  in  8  frame byte, qualified by in_valid.
REQ-008 in_sof / in_eof  in  1 each  first / last byte of frame, qualified by in_valid.
REQ-009 in_err  in  1  rxer seen on this byte, qualified by in_valid.
REQ-010 cfg_we  in  1  config write strobe.
REQ-011 cfg_addr  in  4  0..NUM_IP-1 IP entry; 8 MAC[47:32] (wdata[15:0]); 9 MAC[31:0]; 10 ctrl (wdata[7:0] enable mask, wdata[8] promiscuous).
REQ-012 cfg_wdata  in  32  config data; writes to unmapped addresses are ignored.
REQ-013 verdict_valid  out  1  one-cycle pulse per frame.
REQ-014 verdict_accept  out  1  1 = forward frame, valid with verdict_valid.
REQ-015 verdict_reason  out  3  0 ok, 1 rx error, 2 runt/truncated, 3 MAC miss, 4 not IPv4, 5 IP miss.
REQ-016 accept_cnt / drop_cnt  out  16 each  saturating frame counters.

Function
REQ-017 FSM states: IDLE, DST_MAC, SRC_MAC, ETYPE, IP_HDR, TAIL; byte index counter 11 bits, saturating at 2047.
REQ-018 in_sof with in_valid from any state: index=0, error flag cleared, state DST_MAC.
REQ-019 Offsets: dst MAC bytes 0-5, src MAC 6-11, EtherType 12-13, IP header 14-33, dst IP bytes 30-33, captured into shift registers.
REQ-020 Bytes with in_valid=0 are ignored; index and state advance only on in_valid.
REQ-021 Any in_err byte sets a sticky error flag for the current frame.
REQ-022 MAC match: captured dst == station MAC, or == 48'hFFFFFFFFFFFF, or promiscuous=1.
REQ-023 IP match: captured dst IP equals any entry whose enable-mask bit is 1.
REQ-024 On the in_eof byte, the verdict is registered; verdict_valid pulses exactly one cycle later; state returns to IDLE.
REQ-025 Reason priority: error > runt (eof at index < 33) > MAC miss > EtherType != 16'h0800 > IP miss; accept only when reason = 0.
REQ-026 Compare uses the config values present in the eof cycle; a write in the same cycle takes effect for the next frame.
REQ-027 in_sof while state != IDLE: previous frame gets verdict reason 2, and the new frame starts in the same cycle.
REQ-028 in_sof and in_eof on the same byte: verdict reason 2.
REQ-029 Bytes with in_valid in IDLE and without in_sof are discarded, with no verdict.
REQ-030 On each verdict, accept_cnt or drop_cnt increments by one and holds at 16'hFFFF.

Reset
REQ-031 Reset produces: state IDLE, index 0, verdict_valid 0, verdict_accept 0, verdict_reason 0, both counters 0, MAC = MAC_DEFAULT, entries = IP_BASE+k, enable mask all-ones for NUM_IP bits, promiscuous 0.
REQ-032 Reset mid-frame discards the frame; no verdict is emitted for it.

Structure
REQ-033 Package rx_filter_pkg holds the reason-code constants, header offset constants, the FSM state encoding, and the EtherType 16'h0800.
REQ-034 Sub-module rx_ip_match holds the IP table, enable mask, config decode for entries, and the parallel compare; returns the match bit.

Verification
REQ-035 IPv4 frame, dst MAC 38:6b:1c:1d:f5:65, dst IP 192.168.0.3, 64 bytes -> verdict_valid 1 cycle after eof, accept=1, reason 0, accept_cnt=1.
REQ-036 Same frame with dst IP 192.168.0.9 -> reason 5, drop_cnt=1; then write entry 0 = 192.168.0.9 and resend -> accept.
REQ-037 Broadcast dst, EtherType 0x0806 -> reason 4; non-matching MAC with promiscuous=0 -> reason 3, with promiscuous=1 -> reason 5 or accept per IP.
REQ-038 in_err on byte 20 of a matching frame -> reason 1; 20-byte frame -> reason 2; in_sof at byte 40 -> reason 2 for old frame, new frame judged normally.
REQ-039 70000 accepted frames (forced counter preload acceptable) -> accept_cnt holds 16'hFFFF.
REQ-040 Assert reset at byte 25 -> no verdict, outputs at reset values; the next frame is judged correctly.
